// File: rtl/mp_add_pkg.sv
// Shared types and defaults for the sequential multi-precision adder.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MP_ADD_WIDTH = 8;
  localparam int MP_ADD_WORDS = 4;

  // Slice counter needs at least one bit even when Words == 1.
  function automatic int cnt_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cr_adder.sv
// Width-bit carry-ripple adder slice used once per cycle by mp_add_seq.
module cr_adder #(
  parameter int Width = 8
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             ci,
  output logic [Width-1:0] s,
  output logic             co
);

  logic [Width:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[Width];

endmodule

// File: rtl/mp_add_seq.sv
// Sequential (Width*Words)-bit adder: one Width-bit slice reused over Words cycles.
// Optional subtract mode enabled by defining MP_ADD_SUB_EN.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int Width = MP_ADD_WIDTH,
  parameter int Words = MP_ADD_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Width*Words-1:0] a,
  input  logic [Width*Words-1:0] b,
  input  logic                   c_in,
`ifdef MP_ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Width*Words-1:0] sum,
  output logic                   c_out,
  output logic                   busy
);

  localparam int N  = Width * Words;
  localparam int CW = cnt_width(Words);

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [N-1:0]    a_sr, b_sr;
  logic [N-1:0]    sum_q, sum_next;
  logic            c_out_q;
  logic [Width-1:0] slice_a, slice_b, slice_s;
  logic            slice_co;
  logic            last;
  logic            init_carry;

`ifdef MP_ADD_SUB_EN
  logic sub_q;
  // Subtraction is a + ~b + 1, so the per-slice B is inverted and carry seeded with 1.
  assign slice_b    = b_sr[Width-1:0] ^ {Width{sub_q}};
  assign init_carry = sub | c_in;
`else
  assign slice_b    = b_sr[Width-1:0];
  assign init_carry = c_in;
`endif

  assign slice_a = a_sr[Width-1:0];
  assign last    = (state == RUN) && (cnt == CW'(Words - 1));

  cr_adder #(.Width(Width)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Slice results enter at the MSB end so word 0 ends up at the bottom after Words shifts.
  if (Words == 1) begin : g_one
    assign sum_next = slice_s;
  end else begin : g_multi
    assign sum_next = {slice_s, sum_q[N-1:Width]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carry   <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef MP_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= init_carry;
            cnt   <= '0;
`ifdef MP_ADD_SUB_EN
            sub_q <= sub;
`endif
          end
        end
        RUN: begin
          a_sr  <= a_sr >> Width;
          b_sr  <= b_sr >> Width;
          sum_q <= sum_next;
          carry <= slice_co;
          if (last) begin
            cnt     <= '0;
            c_out_q <= slice_co;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq (Width=8, Words=4); subtract vectors run when MP_ADD_SUB_EN is defined.
module tb_mp_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        c_in;
`ifdef MP_ADD_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        c_out;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  mp_add_seq #(.Width(8), .Words(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef MP_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every consumed result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {31'd0, c_out, sum}, 64'h1_0000_0000_0000);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("result", {31'd0, c_out, sum}, {31'd0, e});
      end
    end
  end

  // Called at posedge+#1 while IDLE; returns at posedge+#1 back in IDLE.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                       input logic ts, input logic [32:0] req);
    int lat;
    a = ta; b = tb_; c_in = tc;
`ifdef MP_ADD_SUB_EN
    sub = ts;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(req);
    a = ~ta; b = ~tb_; c_in = ~tc;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    @(posedge clk); #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    chk("hold_sum", {31'd0, c_out, sum}, {31'd0, req});
  endtask

  initial begin
    int acc_t[3];
    int n, cyc;
    logic [31:0] opa[3], opb[3];
    logic        opc[3];
    logic [32:0] ope[3];
    logic        will_acc;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0;
`ifdef MP_ADD_SUB_EN
    sub = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_sum",       {31'd0, c_out, sum}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 32'h0000_0100});
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 32'h0000_0000});
    do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 32'h0000_0001});

    // Backpressure: result held for 6 cycles, a new request is ignored meanwhile.
    out_ready = 1'b0;
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back({1'b0, 32'h1010_1010});
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_latency", 64'(n), 64'd4);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin a = 32'd1; b = 32'd1; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready",  {63'd0, in_ready},  64'd0);
      chk("bp_sum",       {31'd0, c_out, sum}, {31'd0, 1'b0, 32'h1010_1010});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_back_idle", {63'd0, in_ready}, 64'd1);
    do_op(32'd1, 32'd1, 1'b0, 1'b0, {1'b0, 32'h0000_0002});

    // Reset two cycles into an operation aborts it immediately.
    a = 32'hDEAD_BEEF; b = 32'h0000_0001; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_sum",       {31'd0, c_out, sum}, 64'd0);
    chk("abort_busy",      {63'd0, busy},      64'd0);
    chk("abort_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {1'b0, 32'h2345_6789});

    // Back-to-back with in_valid held high and out_ready tied high.
    opa[0] = 32'h89AB_CDEF; opb[0] = 32'h7654_3210; opc[0] = 1'b0; ope[0] = {1'b0, 32'hFFFF_FFFF};
    opa[1] = 32'hFFFF_FFFF; opb[1] = 32'hFFFF_FFFF; opc[1] = 1'b1; ope[1] = {1'b1, 32'hFFFF_FFFF};
    opa[2] = 32'h8000_0000; opb[2] = 32'h8000_0000; opc[2] = 1'b0; ope[2] = {1'b1, 32'h0000_0000};
    n = 0; cyc = 0;
    a = opa[0]; b = opb[0]; c_in = opc[0]; in_valid = 1'b1;
    while (n < 3 && cyc < 100) begin
      will_acc = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (will_acc) begin
        exp_q.push_back(ope[n]);
        acc_t[n] = cyc;
        n++;
        if (n < 3) begin a = opa[n]; b = opb[n]; c_in = opc[n]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(n), 64'd3);
    chk("b2b_period_1", 64'(acc_t[1] - acc_t[0]), 64'd6);
    chk("b2b_period_2", 64'(acc_t[2] - acc_t[1]), 64'd6);
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end

`ifdef MP_ADD_SUB_EN
    do_op(32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 32'hFFFF_FFFE});
    do_op(32'd7, 32'd5, 1'b0, 1'b1, {1'b1, 32'h0000_0002});
    do_op(32'd7, 32'd5, 1'b0, 1'b0, {1'b0, 32'h0000_000C});
`endif

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
Sequential multi-precision adder controller. It computes an (Width*Words)-bit sum by time-multiplexing a single Width-bit carry-ripple adder slice over Words cycles, holding the carry between slices in a flop.
- Upstream and downstream interfaces use valid/ready handshakes.
- Intended for wide arithmetic (e.g. 32/64-bit) where a full-width ripple chain would fail timing or cost too much area.

Parameters:
- Width, 8: bit width of the adder slice used per cycle; >= 1.
- Words, 4: number of slices per operation; >= 1. Operand width N = Width*Words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and c_in valid.
- in_ready  out  1  block can accept an operation (high only in IDLE).
- a  in  N  operand A.
- b  in  N  operand B.
- c_in  in  1  initial carry into slice 0.
- out_valid  out  1  sum/c_out valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  N  result, registered.
- c_out  out  1  carry out of the top slice, registered.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, carry=0, operand and result registers=0. Outputs: in_ready=1, out_valid=0, sum=0, c_out=0, busy=0.
- FSM states: IDLE, RUN, DONE. Outputs decode from state: in_ready=(IDLE), out_valid=(DONE), busy=!(IDLE).
- IDLE:
  - On in_valid&&in_ready: capture a, b into operand shift registers, carry<=c_in, counter<=0, then go to RUN.
  - in_valid low: stay in IDLE.
- RUN, each cycle:
  - Slice inputs are the low Width bits of the A and B shift registers plus the carry flop.
  - The slice sum is shifted into the result register from the MSB end; operands shift right by Width.
  - carry<=slice carry-out; counter++.
  - On the cycle counter==Words-1: load c_out<=slice carry-out, go to DONE.
- Latency: exactly Words cycles from the accept edge to the edge that raises out_valid. For Words=1, RUN lasts one cycle.
- DONE: sum and c_out are held stable. On out_ready (out_valid&&out_ready) go to IDLE. in_valid is ignored while in DONE (in_ready=0).
- No overlap: a new operation cannot be accepted in the same cycle a result is consumed. The earliest next accept is in the following IDLE cycle.
- sum and c_out keep their last value after returning to IDLE until the next operation overwrites them.
- Arithmetic: sum = (a + b + c_in) mod 2^N; c_out = bit N of the full sum.
- Counter width: max(1, $clog2(Words)). The counter never exceeds Words-1.
- Reset during RUN or DONE: the operation is aborted immediately and the block returns to the reset values; no partial result is visible.
- Inputs a/b/c_in may change after acceptance without affecting the running operation.

Optional Feature:
- Macro MP_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled at accept.
  - sub=1: the B slice is inverted each cycle and the initial carry is forced to 1, giving sum = a - b mod 2^N. c_out=1 means no borrow (a >= b); c_in is ignored.
  - sub=0: addition, as above.
- Undefined: no sub port, add only; logic is identical to the add path.

Decomposition:
- Package mp_add_pkg:
  - State enum typedef (IDLE, RUN, DONE).
  - Default constants MP_ADD_WIDTH=8, MP_ADD_WORDS=4.
  - Function for counter width.
- Sub-module: one instance of cr_adder #(.Width(Width)) as the per-cycle slice. The FSM, counter, carry flop and shift registers stay in mp_add_seq.

Test Plan (Width=8, Words=4):
- Basic add, inter-slice carry: a=0x000000FF, b=0x00000001, c_in=0 -> sum=0x00000100, c_out=0; out_valid rises exactly 4 cycles after the accept edge.
- Full ripple: a=0xFFFFFFFF, b=0x00000001, c_in=0 -> sum=0x00000000, c_out=1. Also a=0, b=0, c_in=1 -> sum=0x00000001, c_out=0.
- Backpressure: out_ready held low 6 cycles after DONE -> sum/out_valid stable, in_ready=0, and an in_valid pulse with a=1, b=1 is ignored. Then out_ready=1 -> IDLE; the next accepted a=1, b=1 gives sum=0x00000002.
- Reset mid-operation: rst_n low 2 cycles after accept -> out_valid=0, sum=0, busy=0, in_ready=1 without waiting for a clock edge. A subsequent a=0x12345678, b=0x11111111 gives sum=0x23456789.
- Back-to-back with out_ready tied high: 3 operations, each accepted one cycle after the previous result is consumed; every result is correct and each occupies Words+2 cycles.
- MP_ADD_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, c_out=0. a=7, b=5, sub=1 -> sum=0x00000002, c_out=1.
